// File: rtl/i2c_arbiter_pkg.sv
// Shared definitions for the i2c_arbiter block.
// FSM state encodings, requester limits and index width.
package i2c_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_REQ = 8;
    localparam int ARB_IDX_W   = 3;

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin picker for i2c_arbiter.
// Search starts one past the last winner and wraps modulo NUM_REQ.
module rr_pick
    import i2c_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [ARB_IDX_W-1:0] last,
    output logic [NUM_REQ-1:0]   win_oh,
    output logic [ARB_IDX_W-1:0] win_idx,
    output logic                 any
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    int idx;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!any && req[IW'(idx)]) begin
                any             = 1'b1;
                win_oh[IW'(idx)] = 1'b1;
                win_idx         = ARB_IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master write channel.
// Optional watchdog on the master handshake: I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
    import i2c_arbiter_pkg::*;
#(
    parameter int          NUM_REQ        = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic [7:0]             m_reg_addr,
    output logic [7:0]             m_data_in,
    output logic                   m_write_en,
    input  logic                   m_done,
    output logic                   busy
);

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ || TIMEOUT_CYCLES < 24'd2)
    begin : g_bad_cfg
        $error("i2c_arbiter: illegal parameter values");
    end

    arb_state_t state_q, state_d;
    logic [ARB_IDX_W-1:0] last_q;

    logic [NUM_REQ-1:0]   win_oh;
    logic [ARB_IDX_W-1:0] win_idx;
    logic                 any;

    logic [NUM_REQ-1:0] gnt_d, done_d, err_d;
    logic [7:0]         addr_d, data_d;
    logic               we_d, busy_d;
    logic               tmo;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .last    (last_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    // Held at zero outside WAIT, so it starts from zero on every entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q != ARB_WAIT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 24'd1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            last_q     <= ARB_IDX_W'(NUM_REQ - 1);
            gnt        <= '0;
            req_done   <= '0;
            req_err    <= '0;
            m_reg_addr <= 8'h00;
            m_data_in  <= 8'h00;
            m_write_en <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt        <= gnt_d;
            req_done   <= done_d;
            req_err    <= err_d;
            m_reg_addr <= addr_d;
            m_data_in  <= data_d;
            m_write_en <= we_d;
            busy       <= busy_d;
            if (state_q == ARB_IDLE && any) begin
                last_q <= win_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (any)           state_d = ARB_WAIT;
            ARB_WAIT: if (m_done || tmo) state_d = ARB_DONE;
            ARB_DONE:                    state_d = ARB_IDLE;
            default:                     state_d = ARB_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered.
    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        err_d  = '0;
        we_d   = 1'b0;
        busy_d = 1'b0;
        addr_d = m_reg_addr;
        data_d = m_data_in;
        unique case (state_q)
            ARB_IDLE: begin
                if (any) begin
                    gnt_d  = win_oh;
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                    addr_d = 8'h00;
                    data_d = 8'h00;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (win_oh[i]) begin
                            addr_d = addr_d | req_addr[8*i +: 8];
                            data_d = data_d | req_data[8*i +: 8];
                        end
                    end
                end
            end
            ARB_WAIT: begin
                busy_d = 1'b1;
                if (m_done || tmo) begin
                    done_d = gnt;
                    err_d  = (tmo && !m_done) ? gnt : '0;
                end else begin
                    gnt_d = gnt;
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter (NUM_REQ=3).
// Timeout section follows I2C_ARB_TIMEOUT_EN.
module tb_i2c_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] req_addr;
    logic [23:0] req_data;
    logic [2:0]  gnt;
    logic [2:0]  req_done;
    logic [2:0]  req_err;
    logic [7:0]  m_reg_addr;
    logic [7:0]  m_data_in;
    logic        m_write_en;
    logic        m_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int s0;

    i2c_arbiter #(
        .NUM_REQ        (3),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .gnt        (gnt),
        .req_done   (req_done),
        .req_err    (req_err),
        .m_reg_addr (m_reg_addr),
        .m_data_in  (m_data_in),
        .m_write_en (m_write_en),
        .m_done     (m_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (m_write_en) strobes++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait for a grant, serve it after two cycles, check done pulse.
    task automatic run_txn(input string tag, input logic [2:0] exp);
        for (int k = 0; k < 10; k++) begin
            if (gnt != 3'b000) break;
            tick();
        end
        check({tag, "_gnt"}, 32'(gnt), 32'(exp));
        check({tag, "_we"}, 32'(m_write_en), 32'd1);
        tick();
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check({tag, "_done"}, 32'(req_done), 32'(exp));
        check({tag, "_gclr"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        req      = 3'b000;
        req_addr = 24'h0;
        req_data = 24'h0;
        m_done   = 1'b0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(m_write_en), 32'd0);
        check("rst_addr", 32'(m_reg_addr), 32'd0);
        check("rst_done", 32'(req_done), 32'd0);
        reset = 1'b1;
        tick();

        // Single request from requester 1
        s0 = strobes;
        req_addr = 24'h00_00_00;
        req_data = 24'h00_AE_00;
        req = 3'b010;
        tick();
        check("sgl_gnt", 32'(gnt), 32'b010);
        check("sgl_addr", 32'(m_reg_addr), 32'h00);
        check("sgl_data", 32'(m_data_in), 32'hAE);
        check("sgl_we", 32'(m_write_en), 32'd1);
        check("sgl_busy", 32'(busy), 32'd1);
        tick();
        check("sgl_we_lo", 32'(m_write_en), 32'd0);
        check("sgl_hold", 32'(gnt), 32'b010);
        repeat (3) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check("sgl_done", 32'(req_done), 32'b010);
        check("sgl_gclr", 32'(gnt), 32'd0);
        check("sgl_dbusy", 32'(busy), 32'd1);
        req = 3'b000;
        tick();
        check("sgl_dlo", 32'(req_done), 32'd0);
        check("sgl_idle", 32'(busy), 32'd0);
        check("sgl_strb", 32'(strobes - s0), 32'd1);

        // Simultaneous requests after a reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        s0 = strobes;
        req = 3'b111;
        run_txn("sim0", 3'b001);
        req = 3'b110;
        run_txn("sim1", 3'b010);
        req = 3'b100;
        run_txn("sim2", 3'b100);
        req = 3'b000;
        tick();
        tick();
        check("sim_strb", 32'(strobes - s0), 32'd3);

        // Requesters 0 and 2 re-request continuously
        req = 3'b101;
        for (int t = 0; t < 6; t++) begin
            run_txn($sformatf("fair%0d", t), (t % 2 == 0) ? 3'b001 : 3'b100);
        end
        req = 3'b000;
        tick();
        tick();

        // Addr change and req drop while waiting
        req_addr = 24'h00_00_12;
        req_data = 24'h00_00_34;
        req = 3'b001;
        tick();
        check("stb_gnt", 32'(gnt), 32'b001);
        req_addr = 24'h00_00_FF;
        req = 3'b000;
        tick();
        tick();
        check("stb_addr", 32'(m_reg_addr), 32'h12);
        check("stb_data", 32'(m_data_in), 32'h34);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check("stb_done", 32'(req_done), 32'b001);
        tick();

        // Reset while waiting on the master
        req_addr = 24'h00_55_00;
        req = 3'b010;
        tick();
        check("rmw_gnt", 32'(gnt), 32'b010);
        tick();
        reset = 1'b0;
        tick();
        check("rmw_gnt0", 32'(gnt), 32'd0);
        check("rmw_busy", 32'(busy), 32'd0);
        check("rmw_addr", 32'(m_reg_addr), 32'd0);
        check("rmw_done", 32'(req_done), 32'd0);
        reset = 1'b1;
        req = 3'b011;
        run_txn("rmw_r0", 3'b001);
        req = 3'b010;
        run_txn("rmw_r1", 3'b010);
        req = 3'b000;
        tick();
        tick();

`ifdef I2C_ARB_TIMEOUT_EN
        req = 3'b001;
        tick();
        check("tmo_gnt", 32'(gnt), 32'b001);
        repeat (15) tick();
        check("tmo_early", 32'(req_done), 32'd0);
        tick();
        check("tmo_done", 32'(req_done), 32'b001);
        check("tmo_err", 32'(req_err), 32'b001);
        req = 3'b000;
        tick();
        check("tmo_elo", 32'(req_err), 32'd0);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check("tmo_sp_g", 32'(gnt), 32'd0);
        tick();
        check("tmo_sp_d", 32'(req_done), 32'd0);
        check("tmo_sp_b", 32'(busy), 32'd0);
`else
        req = 3'b001;
        tick();
        check("ntm_gnt", 32'(gnt), 32'b001);
        repeat (40) tick();
        check("ntm_busy", 32'(busy), 32'd1);
        check("ntm_hold", 32'(gnt), 32'b001);
        check("ntm_err", 32'(req_err), 32'd0);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        check("ntm_done", 32'(req_done), 32'b001);
        check("ntm_err2", 32'(req_err), 32'd0);
        req = 3'b000;
        tick();
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        check("ntm_sp_d", 32'(req_done), 32'd0);
        check("ntm_sp_b", 32'(busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
